pi_bus_bridge: RTL and testbench

PI_BUS_BRIDGE -- requirements
Module: pi_bus_bridge

---
 rtl/pi_bus_bridge.sv | 104 ++++++++++
 tb/tb_pi_bus_bridge.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/pi_bus_bridge.sv
// pi_bus_bridge: queues one requester transaction and replays it inside the next Pi bus slot, with slot timeout
module pi_bus_bridge #(
    parameter int ADDR_WIDTH = 17,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 32
) (
    input  logic                  clk16,
    input  logic                  reset_n,
    input  logic                  pi_select,
    input  logic                  pi_strobe,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic                  bus_addr_oe,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  bus_data_oe,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic                  bus_we
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, ACTIVE, DONE} state_t;
    state_t                r_state;
    logic                  r_sel_q;
    logic                  r_stb_q;
    logic                  r_we;
    logic [CW-1:0]         r_cnt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_rd;
    logic                  r_done;
    logic                  r_err;
    logic                  w_slot_start;
    logic [CW-1:0]         w_cnt_next;
    logic                  w_timeout;
    assign w_slot_start = pi_select & ~r_sel_q;
    assign w_cnt_next   = r_cnt + CW'(1);
    assign w_timeout    = (w_cnt_next == CW'(TIMEOUT - 1));
    assign req_ready    = (r_state == IDLE);
    assign bus_addr_oe  = (r_state == ACTIVE);
    assign bus_data_oe  = (r_state == ACTIVE) & r_we;
    assign bus_we       = (r_state == ACTIVE) & r_we & pi_strobe;
    assign done         = r_done;
    assign err          = r_err;
    assign rd_data      = r_rd;
    assign bus_addr     = r_addr;
    assign bus_data_out = r_data;
    // Slot-edge detect registers plus the transaction FSM; sel_q resets high so a slot already running is not a start
    always_ff @(posedge clk16) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_sel_q <= 1'b1;
            r_stb_q <= 1'b0;
            r_we    <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_rd    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sel_q <= pi_select;
            r_stb_q <= pi_strobe;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we    <= req_we;
                        r_addr  <= req_addr;
                        r_data  <= req_data;
                        r_cnt   <= '0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (w_slot_start) begin
                        r_state <= ACTIVE;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_timeout) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (!r_we && !pi_strobe && r_stb_q) r_rd <= bus_data_in;
                    if (!pi_select) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pi_bus_bridge.sv
// tb_pi_bus_bridge: pre-planned directed + random stimulus, transaction-level expected waveforms, per-cycle compare
module tb_pi_bus_bridge;
    localparam int AW = 17, DW = 8, TO = 32, N = 4000, DIR = 320;
    logic clk16 = 1'b0;
    always #5 clk16 = ~clk16;
    logic reset_n = 1'b0, pi_select = 1'b0, pi_strobe = 1'b0, req_valid = 1'b0, req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0, bus_data_in = '0;
    logic req_ready, done, err, bus_addr_oe, bus_data_oe, bus_we;
    logic [DW-1:0] rd_data, bus_data_out;
    logic [AW-1:0] bus_addr;
    pi_bus_bridge #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk16(clk16), .reset_n(reset_n), .pi_select(pi_select), .pi_strobe(pi_strobe),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
        .req_data(req_data), .done(done), .err(err), .rd_data(rd_data), .bus_addr(bus_addr),
        .bus_addr_oe(bus_addr_oe), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
        .bus_data_in(bus_data_in), .bus_we(bus_we)
    );
    bit rst[N], sel[N], stb[N], valid[N], we_a[N];
    logic [AW-1:0] addr_a[N];
    logic [DW-1:0] data_a[N], din_a[N];
    bit e_ready[N], e_done[N], e_err[N], e_aoe[N], e_doe[N], e_bwe[N], hs[N], cap[N];
    logic [AW-1:0] e_addr[N];
    logic [DW-1:0] e_dout[N], e_rd[N];
    logic s_ready[N], s_done[N], s_err[N], s_aoe[N], s_doe[N], s_bwe[N];
    logic [AW-1:0] s_addr[N];
    logic [DW-1:0] s_dout[N], s_rd[N];
    int errors = 0, checks = 0;

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, t, act, exp);
        end
    endtask

    function automatic bit slot_start(int w);
        return sel[w] && !(rst[w-1] || sel[w-1]);
    endfunction

    function automatic bit stbq(int c);
        return !rst[c-1] && stb[c-1];
    endfunction

    task automatic build();
        bit quiet;
        quiet = 1'b0;
        for (int t = 0; t < N; t++) begin
            din_a[t] = DW'($urandom());
            addr_a[t] = AW'($urandom());
            data_a[t] = DW'($urandom());
            we_a[t] = 1'($urandom());
            if (t < DIR) begin
                sel[t] = (t % 16 < 8) && !(t >= 160 && t < 224);
            end else begin
                if (t % 16 == 0) quiet = ($urandom_range(0, 5) == 0) || (((t / 16) / 8) % 5 == 4);
                sel[t] = !quiet && (t % 16 < 8);
                rst[t] = ($urandom_range(0, 299) == 0);
                valid[t] = ($urandom_range(0, 2) == 0);
            end
            stb[t] = sel[t] && (t % 16 == 2 || t % 16 == 3);
        end
        rst[0] = 1; rst[1] = 1;
        valid[46] = 1; we_a[46] = 1; addr_a[46] = 17'h08000; data_a[46] = 8'hA5;
        valid[92] = 1; we_a[92] = 0;
        din_a[98] = 8'h3C; din_a[99] = 8'h3C; din_a[100] = 8'h3C;
        valid[128] = 1; we_a[128] = 1;
        valid[161] = 1; we_a[161] = 1;
        rst[242] = 1; rst[243] = 1;
        valid[242] = 1; valid[243] = 1; valid[244] = 1; we_a[244] = 0;
        valid[286] = 1; we_a[286] = 1; addr_a[286] = 17'h1F00F; data_a[286] = 8'h5A;
        rst[290] = 1;
    endtask

    task automatic run_model();
        int cur, h, a, d, c, nxt;
        bit ab, w;
        logic [AW-1:0] la;
        logic [DW-1:0] ld, rd;
        cur = 1;
        while (cur < N) begin
            e_ready[cur] = 1;
            if (rst[cur] || !valid[cur]) begin
                cur++;
                continue;
            end
            h = cur; hs[h] = 1; w = we_a[h]; a = 0; ab = 0; nxt = N; d = N;
            for (int k = h + 1; k <= h + TO - 1 && k < N; k++) begin
                if (rst[k]) begin ab = 1; nxt = k + 1; break; end
                if (slot_start(k)) begin a = k + 1; break; end
            end
            if (!ab && a == 0) d = h + TO;
            if (!ab && a != 0) begin
                for (c = a; c < N; c++) begin
                    e_aoe[c] = 1; e_doe[c] = w; e_bwe[c] = w && stb[c];
                    if (rst[c]) begin ab = 1; nxt = c + 1; break; end
                    if (!w && !stb[c] && stbq(c)) cap[c] = 1;
                    if (!sel[c]) begin d = c + 1; break; end
                end
            end
            if (ab) begin
                cur = nxt;
                continue;
            end
            if (d < N) begin e_done[d] = 1; e_err[d] = (a == 0); end
            cur = d + 1;
        end
        la = '0; ld = '0; rd = '0;
        for (int t = 1; t < N; t++) begin
            if (rst[t-1]) begin
                la = '0; ld = '0; rd = '0;
            end else begin
                if (hs[t-1]) begin la = addr_a[t-1]; ld = data_a[t-1]; end
                if (cap[t-1]) rd = din_a[t-1];
            end
            e_addr[t] = la; e_dout[t] = ld; e_rd[t] = rd;
        end
    endtask

    initial begin
        build();
        run_model();
        for (int t = 0; t < N; t++) begin
            @(posedge clk16);
            #1;
            reset_n = !rst[t]; pi_select = sel[t]; pi_strobe = stb[t];
            req_valid = valid[t]; req_we = we_a[t]; req_addr = addr_a[t];
            req_data = data_a[t]; bus_data_in = din_a[t];
            @(negedge clk16);
            s_ready[t] = req_ready; s_done[t] = done; s_err[t] = err; s_aoe[t] = bus_addr_oe;
            s_doe[t] = bus_data_oe; s_bwe[t] = bus_we; s_addr[t] = bus_addr;
            s_dout[t] = bus_data_out; s_rd[t] = rd_data;
            if (t >= 1) begin
                chk("req_ready", t, 32'(req_ready), 32'(e_ready[t]));
                chk("done", t, 32'(done), 32'(e_done[t]));
                if (e_done[t]) chk("err", t, 32'(err), 32'(e_err[t]));
                else chk("err_idle", t, 32'(err), 32'(0));
                chk("bus_addr_oe", t, 32'(bus_addr_oe), 32'(e_aoe[t]));
                chk("bus_data_oe", t, 32'(bus_data_oe), 32'(e_doe[t]));
                chk("bus_we", t, 32'(bus_we), 32'(e_bwe[t]));
                chk("bus_addr", t, 32'(bus_addr), 32'(e_addr[t]));
                chk("bus_data_out", t, 32'(bus_data_out), 32'(e_dout[t]));
                chk("rd_data", t, 32'(rd_data), 32'(e_rd[t]));
            end
        end
        chk("lit_reset_ready", 1, 32'(s_ready[1]), 32'(1));
        chk("lit_reset_done", 1, 32'(s_done[1]), 32'(0));
        chk("lit_reset_rd", 1, 32'(s_rd[1]), 32'(0));
        chk("lit_wr_pre_active", 48, 32'(s_aoe[48]), 32'(0));
        chk("lit_wr_active_first", 49, 32'(s_aoe[49]), 32'(1));
        chk("lit_wr_data_oe", 49, 32'(s_doe[49]), 32'(1));
        chk("lit_wr_active_last", 56, 32'(s_aoe[56]), 32'(1));
        chk("lit_wr_active_end", 57, 32'(s_aoe[57]), 32'(0));
        chk("lit_wr_we2", 50, 32'(s_bwe[50]), 32'(1));
        chk("lit_wr_we3", 51, 32'(s_bwe[51]), 32'(1));
        chk("lit_wr_we4", 52, 32'(s_bwe[52]), 32'(0));
        chk("lit_wr_dout", 50, 32'(s_dout[50]), 32'h000000A5);
        chk("lit_wr_addr", 50, 32'(s_addr[50]), 32'h00008000);
        chk("lit_wr_done", 57, 32'(s_done[57]), 32'(1));
        chk("lit_wr_err", 57, 32'(s_err[57]), 32'(0));
        chk("lit_rd_data", 101, 32'(s_rd[101]), 32'h0000003C);
        chk("lit_rd_data_oe", 100, 32'(s_doe[100]), 32'(0));
        chk("lit_rd_we", 98, 32'(s_bwe[98]), 32'(0));
        chk("lit_rd_done", 105, 32'(s_done[105]), 32'(1));
        chk("lit_hs_slot_skip", 129, 32'(s_aoe[129]), 32'(0));
        chk("lit_hs_slot_next", 145, 32'(s_aoe[145]), 32'(1));
        chk("lit_hs_slot_done", 153, 32'(s_done[153]), 32'(1));
        chk("lit_to_early", 192, 32'(s_done[192]), 32'(0));
        chk("lit_to_done", 193, 32'(s_done[193]), 32'(1));
        chk("lit_to_err", 193, 32'(s_err[193]), 32'(1));
        chk("lit_to_no_oe", 180, 32'(s_aoe[180]), 32'(0));
        chk("lit_rst_mid_ready", 244, 32'(s_ready[244]), 32'(1));
        chk("lit_rst_mid_wait", 250, 32'(s_aoe[250]), 32'(0));
        chk("lit_rst_mid_active", 257, 32'(s_aoe[257]), 32'(1));
        chk("lit_rst_act_we", 290, 32'(s_bwe[290]), 32'(1));
        chk("lit_rst_act_we_off", 291, 32'(s_bwe[291]), 32'(0));
        chk("lit_rst_act_aoe_off", 291, 32'(s_aoe[291]), 32'(0));
        chk("lit_rst_act_doe_off", 291, 32'(s_doe[291]), 32'(0));
        chk("lit_rst_act_ready", 291, 32'(s_ready[291]), 32'(1));
        chk("lit_rst_act_no_done", 297, 32'(s_done[297]), 32'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
